// File: rtl/ldpc_recover_serial_pkg.sv
// Shared defaults and state encoding for the min-sum check-node recover stage.
package ldpc_recover_serial_pkg;

  localparam int unsigned W_DEF    = 10;
  localparam int unsigned DC_DEF   = 8;
  localparam int unsigned IDXW_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/ldpc_recover_serial_posnegx.sv
// Sign-magnitude helper: presents both x and its two's complement negation.
module posnegx #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] posx,
  output logic [W-1:0] negx
);

  assign posx = x;
  assign negx = ~x + W'(1);

endmodule

// File: rtl/ldpc_recover_serial.sv
// Check-node recover: expands one row's min1/min2/index/sign state into DC
// serial check-to-variable messages under a valid/ready handshake.
module ldpc_recover_serial
  import ldpc_recover_serial_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned DC   = DC_DEF,
  parameter int unsigned IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [W-2:0]    min1,
  input  logic [W-2:0]    min2,
  input  logic [IDXW-1:0] min1_idx,
  input  logic [DC-1:0]   signs,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_msg,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last
);

  state_t          state;
  logic [W-2:0]    min1_r;
  logic [W-2:0]    min2_r;
  logic [IDXW-1:0] idx_r;
  logic [DC-1:0]   signs_r;
  logic            tsign_r;

  logic            beat_fire;
  logic            load_fire;

  logic [W-2:0]    s_min1;
  logic [W-2:0]    s_min2;
  logic [IDXW-1:0] s_idx;
  logic [DC-1:0]   s_signs;
  logic            s_tsign;
  logic [IDXW-1:0] nj;
  logic [W-2:0]    mag;
  logic            sbit;
  logic            last_n;
  logic [W-1:0]    posx;
  logic [W-1:0]    negx;
  logic [W-1:0]    msg_n;

  assign beat_fire  = out_valid && out_ready;
  assign load_ready = (state == ST_IDLE) || (beat_fire && out_last);
  assign load_fire  = load_valid && load_ready;

  // The next beat is built from the incoming row on a load (beat 0),
  // otherwise from the stored row at the following column.
  always_comb begin
    s_min1  = min1_r;
    s_min2  = min2_r;
    s_idx   = idx_r;
    s_signs = signs_r;
    s_tsign = tsign_r;
    nj      = out_idx + IDXW'(1);
    if (load_fire) begin
      s_min1  = min1;
      s_min2  = min2;
      s_idx   = min1_idx;
      s_signs = signs;
      s_tsign = ^signs;
      nj      = '0;
    end
    sbit = s_tsign;
    for (int unsigned k = 0; k < DC; k++) begin
      if (nj == IDXW'(k)) sbit = s_tsign ^ s_signs[k];
    end
    mag    = (nj == s_idx) ? s_min2 : s_min1;
    last_n = (nj == IDXW'(DC - 1));
    msg_n  = sbit ? negx : posx;
  end

  posnegx #(.W(W)) u_posnegx (
    .x    ({1'b0, mag}),
    .posx (posx),
    .negx (negx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_msg   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      min1_r    <= '0;
      min2_r    <= '0;
      idx_r     <= '0;
      signs_r   <= '0;
      tsign_r   <= 1'b0;
    end else if (load_fire) begin
      min1_r    <= min1;
      min2_r    <= min2;
      idx_r     <= min1_idx;
      signs_r   <= signs;
      tsign_r   <= ^signs;
      state     <= ST_EMIT;
      out_valid <= 1'b1;
      out_msg   <= msg_n;
      out_idx   <= nj;
      out_last  <= last_n;
    end else if (beat_fire && !out_last) begin
      out_msg   <= msg_n;
      out_idx   <= nj;
      out_last  <= last_n;
    end else if (beat_fire) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule
